shift_reg_multi: RTL and testbench
==================================

// Module: shift_reg_multi
// PURPOSE
//   Parametrised multi-mode shift register: DEPTH stages of WIDTH bits, each stage with a valid flag.
//   Successor to the fixed 2-bit shift register. Adds forward/backward shift, rotate, hold,
//   synchronous flush, a selectable output tap and fill-level status.
//   Serves as a generic delay line / data-alignment buffer in the datapath.
// PARAMETERS
//   WIDTH  2  data bits per stage (>=1)
//   DEPTH  4  number of stages (>=2)
// PORTS
//   clk         in   1                    rising-edge clock
//   reset       in   1                    synchronous, active-high reset
//   mode        in   2                    00 HOLD, 01 SHIFT_FWD, 10 SHIFT_BWD, 11 ROTATE
//   clear       in   1                    synchronous flush of all stages
//   datain      in   WIDTH                data entering the chain
//   in_valid    in   1                    valid flag accompanying datain
//   tap_sel     in   TW=max(1,$clog2(DEPTH)) output stage index
//   dataout     out  WIDTH                data of stage tap_sel
//   out_valid   out  1                    valid flag of stage tap_sel
//   fill_count  out  CW=$clog2(DEPTH+1)   number of valid stages
//   full        out  1                    fill_count == DEPTH
//   empty       out  1                    fill_count == 0
// BEHAVIOUR
//   - State: s[0..DEPTH-1] (WIDTH bits), v[0..DEPTH-1], fill_count register. All update on rising clk only.
//   - Priority per edge: reset > clear > mode.
//   - reset=1: s=0, v=0, fill_count=0 => dataout=0, out_valid=0, empty=1, full=0 from next edge.
//     Reset mid-shift discards all contents; no partial update.
//   - clear=1 (reset=0): identical effect to reset; mode, datain and in_valid ignored that edge.
//   - HOLD: no state change; datain/in_valid ignored.
//   - SHIFT_FWD: s[0]<=datain, v[0]<=in_valid; s[i]<=s[i-1], v[i]<=v[i-1] for i>0; s[D-1] dropped.
//   - SHIFT_BWD: s[D-1]<=datain, v[D-1]<=in_valid; s[i]<=s[i+1], v[i]<=v[i+1]; s[0] dropped.
//   - ROTATE: s[0]<=s[D-1], v[0]<=v[D-1], others as SHIFT_FWD; datain/in_valid ignored;
//     fill_count unchanged.
//   - dataout/out_valid: combinational mux of registered s/v by tap_sel (no extra latency).
//     Data presented with SHIFT_FWD before edge k is visible at tap t after edge k+t.
//   - tap_sel >= DEPTH (non-power-of-2 DEPTH): dataout=0, out_valid=0.
//   - fill_count: registered; loaded each edge with popcount of next-state v (never wraps;
//     range 0..DEPTH). full/empty decoded combinationally from fill_count.
//   - Invalid stages (v=0) still carry data bits; only v is qualified by flags.
//   - mode changes take effect on the same edge they are sampled; no handshake or stall.
// STRUCTURE
//   - Package shift_reg_pkg: localparams MODE_HOLD=2'b00, MODE_FWD=2'b01, MODE_BWD=2'b10,
//     MODE_ROT=2'b11; function popcount for CW width.
//   - Sub-module shift_reg_stage: one WIDTH+1-bit register (data+valid) with sync clear and
//     3:1 next-value mux (hold / from lower neighbour / from upper neighbour);
//     top instantiates DEPTH copies in a generate loop plus tap mux and count logic.
// TESTING  (WIDTH=2, DEPTH=4 unless stated)
//   1 reset=1 for 2 edges, mode=01, in_valid=1 -> dataout=0, out_valid=0, fill_count=0, empty=1, full=0.
//   2 mode=01, in_valid=1, datain 0,1,2,3 on 4 edges -> s0..s3=3,2,1,0; tap_sel=3 gives dataout=0;
//     tap_sel=0 gives 3; fill_count=4, full=1.
//   3 from case 2, mode=11 one edge -> s0=0,s1=3,s2=2,s3=1; after 4 edges total original order
//     restored; fill_count stays 4 throughout.
//   4 from case 2, mode=10, datain=2, in_valid=0 for 2 edges -> s0=1,s1=0, v2=v3=0,
//     fill_count=2, full=0, empty=0.
//   5 mid-SHIFT_FWD assert clear=1 with in_valid=1 one edge -> all v=0, s=0, fill_count=0, empty=1;
//     repeat with reset=1 and clear=1 together -> same result.
//   6 DEPTH=3 instance, fill then mode=00 for 5 edges -> contents and fill_count=3 unchanged;
//     tap_sel=3 -> dataout=0, out_valid=0.

Source files
------------

// File: rtl/shift_reg_multi_pkg.sv
// Shared mode encodings, per-stage next-value select and a popcount helper
// for the multi-mode shift register.
package shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_FWD  = 2'b01;
    localparam logic [1:0] MODE_BWD  = 2'b10;
    localparam logic [1:0] MODE_ROT  = 2'b11;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_LO   = 2'd1,
        SEL_HI   = 2'd2
    } stage_sel_e;

    // Widest valid vector the count helper accepts; callers zero-extend.
    localparam int MAX_DEPTH = 256;

    function automatic int popcount(input logic [MAX_DEPTH-1:0] i_vec);
        int n;
        n = 0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            n += int'(i_vec[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/shift_reg_multi_if.sv
// Control/data bundle between a driver and the shift register; clk/reset
// stay outside as plain ports.
interface shift_reg_multi_if #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
);
    localparam int TW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [1:0]       mode;
    logic             clear;
    logic [WIDTH-1:0] datain;
    logic             in_valid;
    logic [TW-1:0]    tap_sel;
    logic [WIDTH-1:0] dataout;
    logic             out_valid;
    logic [CW-1:0]    fill_count;
    logic             full;
    logic             empty;

    modport master (
        output mode, clear, datain, in_valid, tap_sel,
        input  dataout, out_valid, fill_count, full, empty
    );

    modport slave (
        input  mode, clear, datain, in_valid, tap_sel,
        output dataout, out_valid, fill_count, full, empty
    );

endinterface

// File: rtl/shift_reg_multi_stage.sv
// One data+valid stage: holds, or loads from its lower or upper neighbour;
// exposes its next valid bit so the parent can count fill level.
module shift_reg_stage
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  stage_sel_e       i_sel,
    input  logic [WIDTH-1:0] i_lo_d,
    input  logic             i_lo_v,
    input  logic [WIDTH-1:0] i_hi_d,
    input  logic             i_hi_v,
    output logic [WIDTH-1:0] o_d,
    output logic             o_v,
    output logic             o_nxt_v
);
    logic [WIDTH-1:0] r_d;
    logic             r_v;
    logic [WIDTH-1:0] w_nxt_d;
    logic             w_nxt_v;

    always_comb begin
        w_nxt_d = r_d;
        w_nxt_v = r_v;
        case (i_sel)
            SEL_LO: begin
                w_nxt_d = i_lo_d;
                w_nxt_v = i_lo_v;
            end
            SEL_HI: begin
                w_nxt_d = i_hi_d;
                w_nxt_v = i_hi_v;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_d <= '0;
            r_v <= 1'b0;
        end else begin
            r_d <= w_nxt_d;
            r_v <= w_nxt_v;
        end
    end

    assign o_d     = r_d;
    assign o_v     = r_v;
    assign o_nxt_v = w_nxt_v;

endmodule

// File: rtl/shift_reg_multi.sv
// DEPTH-stage multi-mode shift register (hold / shift fwd / shift bwd / rotate)
// with a combinational output tap and a registered fill count.
module shift_reg_multi
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    shift_reg_multi_if.slave  bus
);
    localparam int TW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] w_s;
    logic [DEPTH-1:0]            w_v;
    logic [DEPTH-1:0]            w_nv;
    stage_sel_e                  w_sel;
    logic [WIDTH-1:0]            w_lo0_d;
    logic                        w_lo0_v;
    logic [CW-1:0]               r_fill;

    // Rotate is a forward shift whose stage-0 input is the last stage.
    always_comb begin
        w_sel   = SEL_HOLD;
        w_lo0_d = bus.datain;
        w_lo0_v = bus.in_valid;
        case (bus.mode)
            MODE_FWD: w_sel = SEL_LO;
            MODE_BWD: w_sel = SEL_HI;
            MODE_ROT: begin
                w_sel   = SEL_LO;
                w_lo0_d = w_s[DEPTH-1];
                w_lo0_v = w_v[DEPTH-1];
            end
            default: w_sel = SEL_HOLD;
        endcase
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic [WIDTH-1:0] w_lo_d;
        logic             w_lo_v;
        logic [WIDTH-1:0] w_hi_d;
        logic             w_hi_v;

        if (g == 0) begin : g_lo_in
            assign w_lo_d = w_lo0_d;
            assign w_lo_v = w_lo0_v;
        end else begin : g_lo_nb
            assign w_lo_d = w_s[g-1];
            assign w_lo_v = w_v[g-1];
        end

        if (g == DEPTH - 1) begin : g_hi_in
            assign w_hi_d = bus.datain;
            assign w_hi_v = bus.in_valid;
        end else begin : g_hi_nb
            assign w_hi_d = w_s[g+1];
            assign w_hi_v = w_v[g+1];
        end

        shift_reg_stage #(.WIDTH(WIDTH)) u_stage (
            .i_clk   (clk),
            .i_rst   (reset),
            .i_clr   (bus.clear),
            .i_sel   (w_sel),
            .i_lo_d  (w_lo_d),
            .i_lo_v  (w_lo_v),
            .i_hi_d  (w_hi_d),
            .i_hi_v  (w_hi_v),
            .o_d     (w_s[g]),
            .o_v     (w_v[g]),
            .o_nxt_v (w_nv[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            r_fill <= '0;
        end else begin
            r_fill <= CW'(popcount(MAX_DEPTH'(w_nv)));
        end
    end

    // Out-of-range taps (non-power-of-2 DEPTH) match no stage and read zero.
    always_comb begin
        bus.dataout   = '0;
        bus.out_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.tap_sel == TW'(i)) begin
                bus.dataout   = w_s[i];
                bus.out_valid = w_v[i];
            end
        end
    end

    assign bus.fill_count = r_fill;
    assign bus.full       = (r_fill == CW'(DEPTH));
    assign bus.empty      = (r_fill == '0);

endmodule

// File: tb/tb_shift_reg_multi.sv
// Scoreboard bench for shift_reg_multi: DEPTH=4 and DEPTH=3 instances driven
// with directed vectors; a negedge monitor sweeps every tap against the queue.
`timescale 1ns/1ps
module tb_shift_reg_multi;

    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    shift_reg_multi_if #(.WIDTH(2), .DEPTH(4)) if4 ();
    shift_reg_multi_if #(.WIDTH(2), .DEPTH(3)) if3 ();

    shift_reg_multi #(.WIDTH(2), .DEPTH(4)) u4 (.clk(clk), .reset(reset), .bus(if4));
    shift_reg_multi #(.WIDTH(2), .DEPTH(3)) u3 (.clk(clk), .reset(reset), .bus(if3));

    typedef struct {
        string          name;
        int             dut;
        logic [3:0][1:0] s;
        logic [3:0]     v;
        int             fill;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    task automatic push(input string n, input int d,
                        input logic [1:0] a0, input logic [1:0] a1,
                        input logic [1:0] a2, input logic [1:0] a3,
                        input logic [3:0] v, input int f);
        exp_t e;
        e.name = n; e.dut = d;
        e.s = {a3, a2, a1, a0};
        e.v = v; e.fill = f;
        q.push_back(e);
    endtask

    task automatic check(input exp_t e);
        logic [1:0]  gd;
        logic        gv;
        logic [31:0] gf;
        logic        gfull, gempty;
        int          depth;
        depth = (e.dut == 0) ? 4 : 3;
        for (int t = 0; t < 4; t++) begin
            if (e.dut == 0) begin
                if4.tap_sel = 2'(t); #1;
                gd = if4.dataout; gv = if4.out_valid;
            end else begin
                if3.tap_sel = 2'(t); #1;
                gd = if3.dataout; gv = if3.out_valid;
            end
            total++;
            if (gd !== e.s[t]) begin
                bad++;
                $display("FAIL %s d%0d tap%0d dataout got=%0d exp=%0d", e.name, e.dut, t, gd, e.s[t]);
            end
            total++;
            if (gv !== e.v[t]) begin
                bad++;
                $display("FAIL %s d%0d tap%0d out_valid got=%0b exp=%0b", e.name, e.dut, t, gv, e.v[t]);
            end
        end
        if (e.dut == 0) begin
            gf = 32'(if4.fill_count); gfull = if4.full; gempty = if4.empty;
        end else begin
            gf = 32'(if3.fill_count); gfull = if3.full; gempty = if3.empty;
        end
        total++;
        if (gf !== 32'(e.fill)) begin
            bad++;
            $display("FAIL %s d%0d fill_count got=%0d exp=%0d", e.name, e.dut, gf, e.fill);
        end
        total++;
        if (gfull !== (e.fill == depth)) begin
            bad++;
            $display("FAIL %s d%0d full got=%0b exp=%0b", e.name, e.dut, gfull, e.fill == depth);
        end
        total++;
        if (gempty !== (e.fill == 0)) begin
            bad++;
            $display("FAIL %s d%0d empty got=%0b exp=%0b", e.name, e.dut, gempty, e.fill == 0);
        end
    endtask

    // Monitor: state settles after posedge; compare on the following negedge.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0) check(q.pop_front());
        end
    end

    task automatic drv4(input logic [1:0] m, input logic c, input logic [1:0] di, input logic iv);
        if4.mode = m; if4.clear = c; if4.datain = di; if4.in_valid = iv;
        @(posedge clk); #1;
    endtask

    task automatic drv3(input logic [1:0] m, input logic c, input logic [1:0] di, input logic iv);
        if3.mode = m; if3.clear = c; if3.datain = di; if3.in_valid = iv;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        if4.mode = 2'b01; if4.clear = 1'b0; if4.datain = 2'd3; if4.in_valid = 1'b1; if4.tap_sel = '0;
        if3.mode = 2'b01; if3.clear = 1'b0; if3.datain = 2'd3; if3.in_valid = 1'b1; if3.tap_sel = '0;

        // reset held two edges while shifting is requested
        @(posedge clk); #1;
        push("rst1", 0, 0, 0, 0, 0, 4'b0000, 0);
        push("rst1", 1, 0, 0, 0, 0, 4'b0000, 0);
        @(posedge clk); #1;
        push("rst2", 0, 0, 0, 0, 0, 4'b0000, 0);
        push("rst2", 1, 0, 0, 0, 0, 4'b0000, 0);
        reset = 1'b0;
        if3.mode = 2'b00;

        // forward fill 0,1,2,3
        drv4(2'b01, 0, 2'd0, 1); push("fwd0", 0, 0, 0, 0, 0, 4'b0001, 1);
        drv4(2'b01, 0, 2'd1, 1); push("fwd1", 0, 1, 0, 0, 0, 4'b0011, 2);
        drv4(2'b01, 0, 2'd2, 1); push("fwd2", 0, 2, 1, 0, 0, 4'b0111, 3);
        drv4(2'b01, 0, 2'd3, 1); push("fwd3", 0, 3, 2, 1, 0, 4'b1111, 4);

        // rotate four times back to the original order; datain ignored
        drv4(2'b11, 0, 2'd1, 0); push("rot1", 0, 0, 3, 2, 1, 4'b1111, 4);
        drv4(2'b11, 0, 2'd1, 0); push("rot2", 0, 1, 0, 3, 2, 4'b1111, 4);
        drv4(2'b11, 0, 2'd1, 0); push("rot3", 0, 2, 1, 0, 3, 4'b1111, 4);
        drv4(2'b11, 0, 2'd1, 0); push("rot4", 0, 3, 2, 1, 0, 4'b1111, 4);

        drv4(2'b00, 0, 2'd1, 0); push("hold", 0, 3, 2, 1, 0, 4'b1111, 4);

        // backward shift of invalid data
        drv4(2'b10, 0, 2'd2, 0); push("bwd1", 0, 2, 1, 0, 2, 4'b0111, 3);
        drv4(2'b10, 0, 2'd2, 0); push("bwd2", 0, 1, 0, 2, 2, 4'b0011, 2);

        // clear mid-shift
        drv4(2'b01, 0, 2'd1, 1); push("fwd4", 0, 1, 1, 0, 2, 4'b0111, 3);
        drv4(2'b01, 1, 2'd3, 1); push("clr",  0, 0, 0, 0, 0, 4'b0000, 0);
        drv4(2'b01, 0, 2'd2, 1); push("fwd5", 0, 2, 0, 0, 0, 4'b0001, 1);
        drv4(2'b01, 0, 2'd3, 1); push("fwd6", 0, 3, 2, 0, 0, 4'b0011, 2);

        // reset and clear together
        reset = 1'b1;
        drv4(2'b01, 1, 2'd1, 1);
        reset = 1'b0;
        push("rstclr", 0, 0, 0, 0, 0, 4'b0000, 0);
        push("rstclr", 1, 0, 0, 0, 0, 4'b0000, 0);

        // backward entry into the top stage from empty
        drv4(2'b10, 0, 2'd1, 1); push("bwdin", 0, 0, 0, 0, 1, 4'b1000, 1);
        if4.mode = 2'b00;

        // DEPTH=3: fill, then hold five edges; tap 3 is out of range
        drv3(2'b01, 0, 2'd1, 1);
        drv3(2'b01, 0, 2'd2, 1); push("d3f2", 1, 2, 1, 0, 0, 4'b0011, 2);
        drv3(2'b01, 0, 2'd3, 1); push("d3f3", 1, 3, 2, 1, 0, 4'b0111, 3);
        for (int k = 0; k < 5; k++) begin
            drv3(2'b00, 0, 2'(k), 1);
            push("d3hold", 1, 3, 2, 1, 0, 4'b0111, 3);
        end

        repeat (3) @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending got=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
